// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the iterative mul/div execute unit: op codes and FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package ex_muldiv_unit_pkg;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_e;

   function automatic logic op_is_div(input op_e op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Zero latency; no flow control, the parent decides when the result is captured.
module ex_muldiv_unit_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          ge;

   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
      shifted = {hi_i, lo_i[XLEN-1]};
      diff    = shifted - {1'b0, opnd_i};
      // A set top bit of the shifted remainder already exceeds any XLEN-bit divisor.
      ge      = shifted[XLEN] | ~diff[XLEN];
      if (is_div_i) begin
         hi_o = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], ge};
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU beside the EX ALU; done_out XLEN+1 cycles after accept.
// Stalls IF/ID and ID/EX while accepting or busy; result is a one-cycle pulse with no downstream backpressure.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start_in,
   input  logic [1:0]      op_in,
   input  logic [XLEN-1:0] data_1_in,
   input  logic [XLEN-1:0] data_2_in,
   input  logic [4:0]      Rd_in,
   input  logic            flush_in,
   output logic            stall_out,
   output logic            busy_out,
   output logic            done_out,
   output logic [XLEN-1:0] result_out,
   output logic [4:0]      Rd_out
);

   state_e            state_q, state_d;
   op_e               op_q;
   logic [CNT_W-1:0]  count_q;
   logic [XLEN-1:0]   opnd_q, hi_q, lo_q;
   logic [XLEN-1:0]   hi_nxt, lo_nxt;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_q, rd_out_q;
   logic              accept, last_step, is_div_in;

   assign is_div_in = op_is_div(op_e'(op_in));
   assign accept    = (state_q == S_IDLE) && start_in && !flush_in;
   assign last_step = (count_q == CNT_W'(XLEN-1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      stall_out = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_BUSY;
               stall_out = 1'b1;
            end
         end
         S_BUSY: begin
            stall_out = 1'b1;
            if (flush_in)       state_d = S_IDLE;
            else if (last_step) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   ex_muldiv_unit_step #(.XLEN(XLEN)) u_step (
      .is_div_i (op_is_div(op_q)),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .opnd_i   (opnd_q),
      .hi_o     (hi_nxt),
      .lo_o     (lo_nxt)
   );

   // Low half carries product-low / quotient, high half product-high / remainder.
   always_comb begin
      result_d = lo_nxt;
      unique case (op_q)
         OP_MULHU, OP_REMU: result_d = hi_nxt;
         default:           result_d = lo_nxt;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= OP_MUL;
         count_q  <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         rd_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else if (accept) begin
         op_q    <= op_e'(op_in);
         count_q <= '0;
         opnd_q  <= is_div_in ? data_2_in : data_1_in;
         lo_q    <= is_div_in ? data_1_in : data_2_in;
         hi_q    <= '0;
         rd_q    <= Rd_in;
      end else if (state_q == S_BUSY) begin
         hi_q    <= hi_nxt;
         lo_q    <= lo_nxt;
         count_q <= count_q + CNT_W'(1);
         if (last_step && !flush_in) begin
            result_q <= result_d;
            rd_out_q <= rd_q;
         end
      end
   end

   assign busy_out   = (state_q != S_IDLE);
   assign done_out   = (state_q == S_DONE);
   assign result_out = result_q;
   assign Rd_out     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: table of ops plus flush, reset and held-start sequences.
module tb_ex_muldiv_unit;

   logic        clk;
   logic        reset_n;
   logic        start_in;
   logic [1:0]  op_in;
   logic [31:0] data_1_in;
   logic [31:0] data_2_in;
   logic [4:0]  Rd_in;
   logic        flush_in;
   logic        stall_out;
   logic        busy_out;
   logic        done_out;
   logic [31:0] result_out;
   logic [4:0]  Rd_out;

   int checks   = 0;
   int failures = 0;

   ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_in   (start_in),
      .op_in      (op_in),
      .data_1_in  (data_1_in),
      .data_2_in  (data_2_in),
      .Rd_in      (Rd_in),
      .flush_in   (flush_in),
      .stall_out  (stall_out),
      .busy_out   (busy_out),
      .done_out   (done_out),
      .result_out (result_out),
      .Rd_out     (Rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Issue one op at the next negedge, drop start after accept, scramble operands, wait for done.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string name);
      int   lat;
      logic stall_ok;
      logic got;
      @(negedge clk);
      op_in = op; data_1_in = a; data_2_in = b; Rd_in = rd; start_in = 1'b1;
      #1;
      stall_ok = (stall_out === 1'b1);
      lat = 0;
      got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) begin
            got = 1'b1;
            lat = k;
            check({name, "_result"}, {32'h0, result_out}, {32'h0, exp});
            check({name, "_rd"}, {59'h0, Rd_out}, {59'h0, rd});
            check({name, "_stall_in_done"}, {63'h0, stall_out}, 64'h0);
         end else if (k <= 32 && stall_out !== 1'b1) begin
            stall_ok = 1'b0;
         end
         if (k == 1) begin
            start_in  = 1'b0;
            op_in     = 2'($urandom_range(3, 0));
            data_1_in = $urandom;
            data_2_in = $urandom;
            Rd_in     = 5'($urandom_range(31, 0));
         end
      end
      check({name, "_latency"}, 64'(lat), 64'd33);
      check({name, "_stall_0_32"}, {63'h0, stall_ok}, 64'h1);
   endtask

   logic [31:0] last_res;
   logic [4:0]  last_rd;
   int          ndone;
   int          done_cyc[2];
   logic [31:0] done_res[2];
   logic [4:0]  done_rd[2];

   initial begin
      vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd3,  32'd42,         "mul_7x6"};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE,  "mulhu_max"};
      vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0001,  "mul_max"};
      vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd7,  32'd14,         "divu_100_7"};
      vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd8,  32'd2,          "remu_100_7"};
      vecs[5] = '{2'b10, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  "divu_by0"};
      vecs[6] = '{2'b11, 32'd5,          32'd0,          5'd10, 32'd5,          "remu_by0"};
      vecs[7] = '{2'b01, 32'h8000_0000,  32'd4,          5'd31, 32'd2,          "mulhu_2p33"};
      vecs[8] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          5'd1,  32'hFFFF_FFFF,  "divu_by1"};
      vecs[9] = '{2'b11, 32'd7,          32'd100,        5'd12, 32'd7,          "remu_small"};

      reset_n = 1'b0; start_in = 1'b0; flush_in = 1'b0;
      op_in = 2'b00; data_1_in = '0; data_2_in = '0; Rd_in = '0;
      #23;
      check("reset_stall",  {63'h0, stall_out}, 64'h0);
      check("reset_busy",   {63'h0, busy_out},  64'h0);
      check("reset_done",   {63'h0, done_out},  64'h0);
      check("reset_result", {32'h0, result_out}, 64'h0);
      check("reset_rd",     {59'h0, Rd_out},    64'h0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].name);
      end
      last_res = vecs[9].exp;
      last_rd  = vecs[9].rd;

      // Flush in BUSY cycle 10.
      @(negedge clk);
      op_in = 2'b00; data_1_in = 32'd3; data_2_in = 32'd3; Rd_in = 5'd20; start_in = 1'b1;
      ndone = 0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) ndone++;
         start_in = 1'b0;
         if (k == 10) begin
            check("flush_busy_before", {63'h0, busy_out}, 64'h1);
            flush_in = 1'b1;
         end
         if (k == 11) begin
            flush_in = 1'b0;
            check("flush_busy_after",  {63'h0, busy_out},  64'h0);
            check("flush_stall_after", {63'h0, stall_out}, 64'h0);
         end
      end
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) ndone++;
      end
      check("flush_no_done", 64'(ndone), 64'd0);
      check("flush_result_kept", {32'h0, result_out}, {32'h0, last_res});
      check("flush_rd_kept", {59'h0, Rd_out}, {59'h0, last_rd});

      // Asynchronous reset mid-BUSY.
      @(negedge clk);
      op_in = 2'b00; data_1_in = 32'd7; data_2_in = 32'd6; Rd_in = 5'd4; start_in = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start_in = 1'b0;
      end
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_stall",  {63'h0, stall_out}, 64'h0);
      check("midrst_busy",   {63'h0, busy_out},  64'h0);
      check("midrst_done",   {63'h0, done_out},  64'h0);
      check("midrst_result", {32'h0, result_out}, 64'h0);
      check("midrst_rd",     {59'h0, Rd_out},    64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) ndone++;
      end
      check("midrst_no_done", 64'(ndone), 64'd0);
      do_op(2'b10, 32'd100, 32'd7, 5'd2, 32'd14, "post_reset_divu");

      // start_in held through DONE; second op presented in the following IDLE cycle.
      @(negedge clk);
      op_in = 2'b00; data_1_in = 32'd7; data_2_in = 32'd6; Rd_in = 5'd1; start_in = 1'b1;
      ndone = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (done_out === 1'b1) begin
            if (ndone < 2) begin
               done_cyc[ndone] = c;
               done_res[ndone] = result_out;
               done_rd[ndone]  = Rd_out;
            end
            ndone++;
         end
         if (c == 33) check("hold_stall_in_done", {63'h0, stall_out}, 64'h0);
         if (c == 34) begin
            check("hold_stall_reaccept", {63'h0, stall_out}, 64'h1);
            op_in = 2'b10; data_1_in = 32'd100; data_2_in = 32'd7; Rd_in = 5'd6;
         end
         if (c == 67) start_in = 1'b0;
      end
      check("hold_done_count", 64'(ndone), 64'd2);
      if (ndone >= 2) begin
         check("hold_first_cycle",  64'(done_cyc[0]), 64'd33);
         check("hold_pitch",        64'(done_cyc[1] - done_cyc[0]), 64'd34);
         check("hold_first_result", {32'h0, done_res[0]}, 64'd42);
         check("hold_first_rd",     {59'h0, done_rd[0]},  64'd1);
         check("hold_second_result",{32'h0, done_res[1]}, 64'd14);
         check("hold_second_rd",    {59'h0, done_rd[1]},  64'd6);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
